// File: rtl/mux_rr_nx1.sv
// N-to-1 registered mux with per-channel valid/ready and fixed-select or round-robin arbitration.
// Optional registered even-parity output enabled by defining MUX_PARITY_EN.
module mux_rr_nx1 #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef MUX_PARITY_EN
   ,
   output logic                    out_parity
`endif
);

   localparam logic [SEL_W:0]   N_LIM    = (SEL_W+1)'(NUM_IN);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

   logic [WIDTH-1:0]    chan_data [NUM_IN];
   logic                load;
   logic                fix_vld;
   logic                rr_vld;
   logic [SEL_W-1:0]    rr_off;
   logic [SEL_W-1:0]    rr_idx;
   logic [SEL_W:0]      rr_sum;
   logic [2*NUM_IN-1:0] valid_dbl;
   logic [NUM_IN-1:0]   valid_rot;
   logic                grant_vld;
   logic [SEL_W-1:0]    grant_idx;
   logic [WIDTH-1:0]    grant_data;

   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic [SEL_W-1:0]    out_src_q, out_src_d;
   logic                out_valid_q, out_valid_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         chan_data[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign load = !out_valid_q || out_ready;

   // Fixed mode: a sel value beyond the last channel matches nothing, so no grant.
   always_comb begin
      fix_vld = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel == SEL_W'(i) && in_valid[i]) begin
            fix_vld = 1'b1;
         end
      end
   end

   // Round-robin: rotate valids so bit 0 is the channel at rr_ptr, take the lowest set bit.
   always_comb begin
      valid_dbl = {in_valid, in_valid};
      valid_rot = NUM_IN'(valid_dbl >> rr_ptr_q);
      rr_vld    = 1'b0;
      rr_off    = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (valid_rot[k]) begin
            rr_vld = 1'b1;
            rr_off = SEL_W'(k);
         end
      end
      rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
      if (rr_sum >= N_LIM) begin
         rr_sum = rr_sum - N_LIM;
      end
      rr_idx = rr_sum[SEL_W-1:0];
   end

   always_comb begin
      if (mode) begin
         grant_vld = rr_vld;
         grant_idx = rr_idx;
      end else begin
         grant_vld = fix_vld;
         grant_idx = sel;
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            grant_data = chan_data[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         in_ready[i] = rst_n && load && grant_vld && (grant_idx == SEL_W'(i));
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         if (grant_vld) begin
            out_data_d  = grant_data;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
               rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

`ifdef MUX_PARITY_EN
   logic out_parity_q, out_parity_d;

   always_comb begin
      out_parity_d = out_parity_q;
      if (load && grant_vld) begin
         out_parity_d = ^grant_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_parity_q <= 1'b0;
      end else begin
         out_parity_q <= out_parity_d;
      end
   end

   assign out_parity = out_parity_q;
`endif

endmodule

// File: doc/mux_rr_nx1.md
Name: mux_rr_nx1

Overview:
- Parametrised N-to-1 registered multiplexer for the datapath; the successor to the combinational 32-bit 2-to-1 mux.
- Each input channel has a valid/ready handshake; the output is a single-entry register with its own valid/ready.
- Two select modes: fixed select from an external sel input, or round-robin arbitration across valid channels.
- Sits between multiple producers (e.g. ALU result, memory read data, PC+4) and one registered consumer.

Parameters:
- WIDTH, 32, data width of each channel.
- NUM_IN, 4, number of input channels; legal range is 2 or more.
- SEL_W, $clog2(NUM_IN), width of sel and out_src.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel accept; one-hot or zero.
- mode  input  1  0 = fixed select via sel, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (Rst_n=0, asynchronous): out_valid=0, out_data=0, out_src=0, rr_ptr=0. in_ready=0 while reset is asserted.
- Asserting reset mid-transfer drops the held word; no output handshake completes on that edge.
- Load condition: load = !out_valid || out_ready. A combinational path from out_ready to in_ready is permitted.
- Grant, fixed mode (mode=0):
  - grant = sel when in_valid[sel]=1 and sel < NUM_IN.
  - Otherwise there is no grant, including when sel >= NUM_IN; all in_ready stay 0.
- Grant, round-robin mode (mode=1):
  - grant = the first channel with in_valid=1, searching from rr_ptr upward and wrapping from NUM_IN-1 to 0.
  - If no channel is valid, there is no grant.
- in_ready[i] = load && (grant==i). At most one bit is set.
- On the clock edge when load and a grant both hold:
  - out_data <= channel data; out_src <= grant; out_valid <= 1.
  - In round-robin mode only, rr_ptr <= grant+1, wrapping to 0 at NUM_IN.
- On the clock edge when load holds with no grant:
  - out_valid <= 0; out_data and out_src hold their values.
- When out_valid=1 and out_ready=0: out_data, out_src and out_valid hold, and all in_ready are 0 (backpressure).
- Latency is 1 cycle from input handshake to out_valid. Throughput is 1 word per cycle when out_ready is held at 1.
- Simultaneous consume and load: the old word leaves and the new word enters on the same edge; out_valid stays 1.
- Mode change: takes effect for the next grant. rr_ptr is not cleared by a mode change and is not updated while in fixed mode.
- sel is sampled only when mode=0; sel values are ignored in mode=1.
- No data reordering: each accepted word appears exactly once on out_data.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit), registered alongside out_data.
  - out_parity equals the even parity (XOR reduction) of the loaded data word.
  - Reset value is 0; it holds under backpressure with out_data.
- Undefined: port absent; no parity logic is generated.

Test Plan:
1. Fixed mode, NUM_IN=2, out_ready=1:
   - in0=32'h00000001, in1=32'h00000002, both valid, sel=0 -> next cycle out_data=32'h00000001, out_src=0, in_ready=2'b01.
   - Then sel=1 -> out_data=32'h00000002, out_src=1.
2. Round-robin mode, NUM_IN=4, all valid continuously, out_ready=1:
   - in0..in3 = 32'hFFFFFFFF, 32'h9864F1D9, 32'hF0000001, 32'hF0000002.
   - Required: out_src sequence 0,1,2,3,0; out_valid stays 1 every cycle after the first.
3. Backpressure:
   - Load 32'hF0000001, then hold out_ready=0 for 5 cycles -> out_data, out_valid and out_src are stable; in_ready=0 throughout.
   - Raise out_ready -> the next grant loads on that edge.
4. Round-robin skip and wrap:
   - Only in1 and in3 valid, rr_ptr=2 -> grants in order 3, 1, 3; channels 0 and 2 never get in_ready.
5. Fixed mode with sel=3 but in_valid=4'b0111 -> no grant, out_valid falls to 0 after the held word is consumed; all in_ready stay 0.
6. Reset: assert Rst_n=0 asynchronously mid-stream while out_valid=1 -> out_valid=0, out_data=0 immediately without a clock edge. After release, the first round-robin grant is channel 0.
   - With MUX_PARITY_EN defined: loading 32'h00000003 gives out_parity=0; loading 32'h00000001 gives out_parity=1.
